// File: rtl/plab3_mem_l2_req_arbiter_pkg.sv
// Shared definitions for the L2 request arbiters (2-port now, 4-port later).
//   ARB_ID_NBITS   : width of a requester id
//   arb_state_e    : arbiter FSM state encoding
//   mem_req_nbits  : width of a memory request message (type, opaque, addr, len, data)
//   mem_resp_nbits : width of a memory response message (type, opaque, test, len, data)
package plab3_mem_l2_req_arbiter_pkg;

  localparam int unsigned ARB_ID_NBITS = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  function automatic int unsigned mem_req_nbits(input int unsigned o, input int unsigned a,
                                                input int unsigned d);
    return 3 + o + a + $clog2(d / 8) + d;
  endfunction

  function automatic int unsigned mem_resp_nbits(input int unsigned o, input int unsigned d);
    return 3 + o + 2 + $clog2(d / 8) + d;
  endfunction

endpackage

// File: rtl/plab3_mem_l2_req_arbiter_slot_timer.sv
// Time-division slot timer for the L2 request arbiter.
//   clk, reset   : clock, synchronous active-high reset
//   busy         : arbiter has a transaction outstanding (not IDLE)
//   slot_open    : first cycle of a slot (slot_cnt == 0), accepts allowed
//   slot_owner   : requester id that owns the current slot
//   slot_overrun : sticky, a slot boundary was reached while busy
module plab3_mem_l2_req_arbiter_slot_timer
  import plab3_mem_l2_req_arbiter_pkg::*;
#(
  parameter int unsigned p_slot_cycles = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    busy,
  output logic                    slot_open,
  output logic [ARB_ID_NBITS-1:0] slot_owner,
  output logic                    slot_overrun
);

  localparam int unsigned cnt_nbits = $clog2(p_slot_cycles);
  localparam logic [cnt_nbits-1:0] cnt_last = cnt_nbits'(p_slot_cycles - 1);

  logic [cnt_nbits-1:0] slot_cnt;

  // Slot counter; the last count holds while a transaction is still outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt     <= '0;
      slot_owner   <= '0;
      slot_overrun <= 1'b0;
    end else if (slot_cnt == cnt_last) begin
      if (busy) begin
        slot_overrun <= 1'b1;
      end else begin
        slot_cnt   <= '0;
        slot_owner <= ~slot_owner;
      end
    end else begin
      slot_cnt <= slot_cnt + cnt_nbits'(1);
    end
  end

  assign slot_open = !reset && (slot_cnt == '0);

endmodule

// File: rtl/plab3_mem_l2_req_arbiter.sv
// Shares one blocking L2 cache between two L1 requesters. One request is
// buffered, forwarded to the L2, and the response is routed back to its issuer.
//   clk, reset                      : clock, synchronous active-high reset
//   req{0,1}_msg/_val/_rdy          : L1-side request ports
//   resp{0,1}_msg/_val/_rdy         : L1-side response ports
//   cachereq_msg/_val/_rdy          : request to the L2
//   cacheresp_msg/_val/_rdy         : response from the L2
//   slot_overrun                    : sticky TDM slot overrun flag (0 in round-robin mode)
module plab3_mem_l2_req_arbiter
  import plab3_mem_l2_req_arbiter_pkg::*;
#(
  parameter int unsigned p_opaque_nbits = 8,
  parameter int unsigned p_addr_nbits   = 32,
  parameter int unsigned p_data_nbits   = 128,
  parameter bit          p_tdm_en       = 1'b0,
  parameter int unsigned p_slot_cycles  = 64
) (
  input  logic clk,
  input  logic reset,

  input  logic [mem_req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)-1:0] req0_msg,
  input  logic                                                                  req0_val,
  output logic                                                                  req0_rdy,
  input  logic [mem_req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)-1:0] req1_msg,
  input  logic                                                                  req1_val,
  output logic                                                                  req1_rdy,

  output logic [mem_resp_nbits(p_opaque_nbits, p_data_nbits)-1:0] resp0_msg,
  output logic                                                     resp0_val,
  input  logic                                                     resp0_rdy,
  output logic [mem_resp_nbits(p_opaque_nbits, p_data_nbits)-1:0] resp1_msg,
  output logic                                                     resp1_val,
  input  logic                                                     resp1_rdy,

  output logic [mem_req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)-1:0] cachereq_msg,
  output logic                                                                  cachereq_val,
  input  logic                                                                  cachereq_rdy,

  input  logic [mem_resp_nbits(p_opaque_nbits, p_data_nbits)-1:0] cacheresp_msg,
  input  logic                                                     cacheresp_val,
  output logic                                                     cacheresp_rdy,

  output logic slot_overrun
);

  localparam int unsigned req_nbits = mem_req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits);

  arb_state_e              state;
  logic [ARB_ID_NBITS-1:0] owner;
  logic [req_nbits-1:0]    req_buf;
  logic [ARB_ID_NBITS-1:0] grant_id;
  logic                    grant_val;
  logic                    accept;
  logic                    owner_rdy;
  logic                    in_wait;
  logic                    resp_fire;

  assign accept    = !reset && (state == ST_IDLE) && grant_val;
  assign in_wait   = !reset && (state == ST_WAIT);
  assign owner_rdy = (owner == '0) ? resp0_rdy : resp1_rdy;
  assign resp_fire = cacheresp_val && cacheresp_rdy;

  // Transaction FSM: accept, forward to L2, wait for the single response
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      owner <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          state <= ST_SEND;
          owner <= grant_id;
        end
        ST_SEND: if (cachereq_rdy) state <= ST_WAIT;
        ST_WAIT: if (resp_fire) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request buffer; contents are meaningless outside SEND
  always_ff @(posedge clk) begin
    if (accept) req_buf <= (grant_id == ARB_ID_NBITS'(1)) ? req1_msg : req0_msg;
  end

  assign req0_rdy = accept && (grant_id == '0);
  assign req1_rdy = accept && (grant_id == ARB_ID_NBITS'(1));

  assign cachereq_val = !reset && (state == ST_SEND);
  assign cachereq_msg = req_buf;

  // Responses only flow in WAIT; anything earlier is left unacknowledged
  assign cacheresp_rdy = in_wait && owner_rdy;
  assign resp0_val     = in_wait && (owner == '0) && cacheresp_val;
  assign resp1_val     = in_wait && (owner == ARB_ID_NBITS'(1)) && cacheresp_val;
  assign resp0_msg     = cacheresp_msg;
  assign resp1_msg     = cacheresp_msg;

  generate
    if (p_tdm_en) begin : g_tdm
      logic                    slot_open;
      logic [ARB_ID_NBITS-1:0] slot_owner;

      plab3_mem_l2_req_arbiter_slot_timer #(
        .p_slot_cycles (p_slot_cycles)
      ) slot_timer (
        .clk          (clk),
        .reset        (reset),
        .busy         (state != ST_IDLE),
        .slot_open    (slot_open),
        .slot_owner   (slot_owner),
        .slot_overrun (slot_overrun)
      );

      // Only the slot owner may be accepted, and only at the start of its slot
      assign grant_id  = slot_owner;
      assign grant_val = slot_open && ((slot_owner == '0) ? req0_val : req1_val);
    end else begin : g_rr
      logic [ARB_ID_NBITS-1:0] prio;

      // Priority passes to the other requester after every grant
      always_ff @(posedge clk) begin
        if (reset)       prio <= '0;
        else if (accept) prio <= ~grant_id;
      end

      assign grant_id     = (req0_val && req1_val) ? prio
                          : (req1_val ? ARB_ID_NBITS'(1) : '0);
      assign grant_val    = req0_val || req1_val;
      assign slot_overrun = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_plab3_mem_l2_req_arbiter.sv
// Bench for plab3_mem_l2_req_arbiter: one round-robin instance and one TDM
// instance (16-cycle slots) sharing clock and reset.
module tb_plab3_mem_l2_req_arbiter;
  import plab3_mem_l2_req_arbiter_pkg::*;

  localparam int unsigned O      = 8;
  localparam int unsigned A      = 32;
  localparam int unsigned D      = 128;
  localparam int unsigned REQ_W  = mem_req_nbits(O, A, D);
  localparam int unsigned RESP_W = mem_resp_nbits(O, D);

  logic clk;
  logic reset;

  logic [REQ_W-1:0]  r_req0_msg, r_req1_msg, r_cachereq_msg;
  logic              r_req0_val, r_req1_val, r_req0_rdy, r_req1_rdy;
  logic [RESP_W-1:0] r_resp0_msg, r_resp1_msg, r_cacheresp_msg;
  logic              r_resp0_val, r_resp1_val, r_resp0_rdy, r_resp1_rdy;
  logic              r_cachereq_val, r_cachereq_rdy, r_cacheresp_val, r_cacheresp_rdy;
  logic              r_slot_overrun;

  logic [REQ_W-1:0]  t_req0_msg, t_req1_msg, t_cachereq_msg;
  logic              t_req0_val, t_req1_val, t_req0_rdy, t_req1_rdy;
  logic [RESP_W-1:0] t_resp0_msg, t_resp1_msg, t_cacheresp_msg;
  logic              t_resp0_val, t_resp1_val, t_resp0_rdy, t_resp1_rdy;
  logic              t_cachereq_val, t_cachereq_rdy, t_cacheresp_val, t_cacheresp_rdy;
  logic              t_slot_overrun;

  plab3_mem_l2_req_arbiter #(
    .p_opaque_nbits (O), .p_addr_nbits (A), .p_data_nbits (D),
    .p_tdm_en (1'b0), .p_slot_cycles (64)
  ) u_rr (
    .clk (clk), .reset (reset),
    .req0_msg (r_req0_msg), .req0_val (r_req0_val), .req0_rdy (r_req0_rdy),
    .req1_msg (r_req1_msg), .req1_val (r_req1_val), .req1_rdy (r_req1_rdy),
    .resp0_msg (r_resp0_msg), .resp0_val (r_resp0_val), .resp0_rdy (r_resp0_rdy),
    .resp1_msg (r_resp1_msg), .resp1_val (r_resp1_val), .resp1_rdy (r_resp1_rdy),
    .cachereq_msg (r_cachereq_msg), .cachereq_val (r_cachereq_val), .cachereq_rdy (r_cachereq_rdy),
    .cacheresp_msg (r_cacheresp_msg), .cacheresp_val (r_cacheresp_val),
    .cacheresp_rdy (r_cacheresp_rdy), .slot_overrun (r_slot_overrun)
  );

  plab3_mem_l2_req_arbiter #(
    .p_opaque_nbits (O), .p_addr_nbits (A), .p_data_nbits (D),
    .p_tdm_en (1'b1), .p_slot_cycles (16)
  ) u_tdm (
    .clk (clk), .reset (reset),
    .req0_msg (t_req0_msg), .req0_val (t_req0_val), .req0_rdy (t_req0_rdy),
    .req1_msg (t_req1_msg), .req1_val (t_req1_val), .req1_rdy (t_req1_rdy),
    .resp0_msg (t_resp0_msg), .resp0_val (t_resp0_val), .resp0_rdy (t_resp0_rdy),
    .resp1_msg (t_resp1_msg), .resp1_val (t_resp1_val), .resp1_rdy (t_resp1_rdy),
    .cachereq_msg (t_cachereq_msg), .cachereq_val (t_cachereq_val), .cachereq_rdy (t_cachereq_rdy),
    .cacheresp_msg (t_cacheresp_msg), .cacheresp_val (t_cacheresp_val),
    .cacheresp_rdy (t_cacheresp_rdy), .slot_overrun (t_slot_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk1(input string nm, input logic act, input logic want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, want);
    end
  endtask

  task automatic chkw(input string nm, input logic [255:0] act, input logic [255:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r_req0_val = 1'b0; r_req1_val = 1'b0; r_cachereq_rdy = 1'b0; r_cacheresp_val = 1'b0;
    r_resp0_rdy = 1'b0; r_resp1_rdy = 1'b0;
    t_req0_val = 1'b0; t_req1_val = 1'b0; t_cachereq_rdy = 1'b0; t_cacheresp_val = 1'b0;
    t_resp0_rdy = 1'b0; t_resp1_rdy = 1'b0;
  endtask

  // All handshake outputs of both instances must be low while reset is high
  task automatic chk_reset_quiet(input string tag);
    chk1({tag, "_rr_req0_rdy"}, r_req0_rdy, 1'b0);
    chk1({tag, "_rr_req1_rdy"}, r_req1_rdy, 1'b0);
    chk1({tag, "_rr_cachereq_val"}, r_cachereq_val, 1'b0);
    chk1({tag, "_rr_resp0_val"}, r_resp0_val, 1'b0);
    chk1({tag, "_rr_resp1_val"}, r_resp1_val, 1'b0);
    chk1({tag, "_rr_cacheresp_rdy"}, r_cacheresp_rdy, 1'b0);
    chk1({tag, "_tdm_req0_rdy"}, t_req0_rdy, 1'b0);
    chk1({tag, "_tdm_req1_rdy"}, t_req1_rdy, 1'b0);
    chk1({tag, "_tdm_cachereq_val"}, t_cachereq_val, 1'b0);
    chk1({tag, "_tdm_resp0_val"}, t_resp0_val, 1'b0);
    chk1({tag, "_tdm_resp1_val"}, t_resp1_val, 1'b0);
    chk1({tag, "_tdm_cacheresp_rdy"}, t_cacheresp_rdy, 1'b0);
  endtask

  // Field order: inputs r0v r1v crdy cval p0rdy p1rdy, then expected
  // req0_rdy req1_rdy cachereq_val resp0_val resp1_val cacheresp_rdy, then
  // which request message cachereq_msg must carry (0, 1, or 3 = unchecked)
  typedef struct packed {
    logic       r0v, r1v, crdy, cval, p0rdy, p1rdy;
    logic       e_r0rdy, e_r1rdy, e_cqval, e_p0val, e_p1val, e_cprdy;
    logic [1:0] e_src;
  } vec_t;

  vec_t vecs [0:18];

  logic [REQ_W-1:0]  m0_msg, m1_msg;
  logic [RESP_W-1:0] rsp_msg;

  // Round-robin reference: a request is either absent, waiting to reach the
  // L2, or waiting for its response; priority goes to whoever was not last served
  bit               m_busy, m_sent, m_owner, m_prio;
  logic [REQ_W-1:0] m_buf;

  initial begin
    m0_msg  = {3'd0, 8'h05, 32'h0000_1000, 4'd0, 128'h0};
    m1_msg  = {3'd0, 8'h0a, 32'h0000_2000, 4'd0, 128'h0};
    rsp_msg = {3'd0, 8'h05, 2'd0, 4'd0, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210};

    vecs[0]  = 14'b101011_100000_11;  // req0 alone, accepted
    vecs[1]  = 14'b001011_001000_00;  // forwarded to L2 one cycle later
    vecs[2]  = 14'b001111_000101_11;  // response goes to requester 0 only
    vecs[3]  = 14'b110011_010000_11;  // both valid, priority now at 1
    vecs[4]  = 14'b110011_001000_01;  // L2 stalls, no second accept
    vecs[5]  = 14'b111011_001000_01;
    vecs[6]  = 14'b000110_000010_11;  // owner not ready, response held
    vecs[7]  = 14'b000101_000011_11;  // owner ready, transfer
    vecs[8]  = 14'b110011_100000_11;  // both valid, priority back at 0
    vecs[9]  = 14'b001111_001000_00;  // response during SEND is not taken
    vecs[10] = 14'b000111_000101_11;
    vecs[11] = 14'b111011_010000_11;
    vecs[12] = 14'b001111_001000_01;
    vecs[13] = 14'b000001_000001_11;  // rdy follows owner even without val
    vecs[14] = 14'b000111_000011_11;
    vecs[15] = 14'b001111_000000_11;  // stray response in IDLE not routed
    vecs[16] = 14'b010011_010000_11;  // lone req1 wins against priority 0
    vecs[17] = 14'b001011_001000_01;
    vecs[18] = 14'b000111_000011_11;

    idle_inputs();
    r_req0_msg = m0_msg; r_req1_msg = m1_msg; r_cacheresp_msg = rsp_msg;
    t_req0_msg = m0_msg; t_req1_msg = m1_msg; t_cacheresp_msg = rsp_msg;

    // Reset with everything requesting
    reset = 1'b1;
    r_req0_val = 1'b1; r_req1_val = 1'b1; r_cacheresp_val = 1'b1; r_resp0_rdy = 1'b1;
    t_req0_val = 1'b1; t_req1_val = 1'b1; t_cacheresp_val = 1'b1; t_resp0_rdy = 1'b1;
    next_cycle();
    @(negedge clk);
    chk_reset_quiet("reset");
    next_cycle();
    reset = 1'b0;
    idle_inputs();

    // Directed round-robin table
    for (int i = 0; i < 19; i++) begin
      r_req0_val = vecs[i].r0v;   r_req1_val = vecs[i].r1v;
      r_cachereq_rdy = vecs[i].crdy; r_cacheresp_val = vecs[i].cval;
      r_resp0_rdy = vecs[i].p0rdy; r_resp1_rdy = vecs[i].p1rdy;
      @(negedge clk);
      chk1($sformatf("vec%0d_req0_rdy", i), r_req0_rdy, vecs[i].e_r0rdy);
      chk1($sformatf("vec%0d_req1_rdy", i), r_req1_rdy, vecs[i].e_r1rdy);
      chk1($sformatf("vec%0d_cachereq_val", i), r_cachereq_val, vecs[i].e_cqval);
      chk1($sformatf("vec%0d_resp0_val", i), r_resp0_val, vecs[i].e_p0val);
      chk1($sformatf("vec%0d_resp1_val", i), r_resp1_val, vecs[i].e_p1val);
      chk1($sformatf("vec%0d_cacheresp_rdy", i), r_cacheresp_rdy, vecs[i].e_cprdy);
      if (vecs[i].e_src != 2'd3)
        chkw($sformatf("vec%0d_cachereq_msg", i), 256'(r_cachereq_msg),
             256'((vecs[i].e_src == 2'd1) ? m1_msg : m0_msg));
      if (vecs[i].e_p0val)
        chkw($sformatf("vec%0d_resp0_opaque", i), 256'(r_resp0_msg[RESP_W-4 -: 8]), 256'(8'h05));
      if (vecs[i].e_p1val)
        chkw($sformatf("vec%0d_resp1_msg", i), 256'(r_resp1_msg), 256'(rsp_msg));
      next_cycle();
    end

    // Randomized round-robin against the reference
    m_busy = 1'b0; m_sent = 1'b0; m_owner = 1'b0; m_prio = 1'b0; m_buf = '0;
    for (int i = 0; i < 400; i++) begin
      bit any, win, acc, waiting, own_rdy;
      r_req0_val      = ($urandom_range(0, 2) != 0);
      r_req1_val      = ($urandom_range(0, 2) != 0);
      r_cachereq_rdy  = ($urandom_range(0, 3) != 0);
      r_cacheresp_val = ($urandom_range(0, 2) != 0);
      r_resp0_rdy     = ($urandom_range(0, 3) != 0);
      r_resp1_rdy     = ($urandom_range(0, 3) != 0);
      r_req0_msg      = REQ_W'(rnd256());
      r_req1_msg      = REQ_W'(rnd256());
      r_cacheresp_msg = RESP_W'(rnd256());
      @(negedge clk);
      any     = r_req0_val || r_req1_val;
      win     = (r_req0_val && r_req1_val) ? m_prio : r_req1_val;
      acc     = !m_busy && any;
      waiting = m_busy && m_sent;
      own_rdy = m_owner ? r_resp1_rdy : r_resp0_rdy;
      chk1("rnd_req0_rdy", r_req0_rdy, acc && !win);
      chk1("rnd_req1_rdy", r_req1_rdy, acc && win);
      chk1("rnd_cachereq_val", r_cachereq_val, m_busy && !m_sent);
      if (m_busy && !m_sent) chkw("rnd_cachereq_msg", 256'(r_cachereq_msg), 256'(m_buf));
      chk1("rnd_resp0_val", r_resp0_val, waiting && !m_owner && r_cacheresp_val);
      chk1("rnd_resp1_val", r_resp1_val, waiting && m_owner && r_cacheresp_val);
      chk1("rnd_cacheresp_rdy", r_cacheresp_rdy, waiting && own_rdy);
      if (r_resp0_val) chkw("rnd_resp0_msg", 256'(r_resp0_msg), 256'(r_cacheresp_msg));
      if (r_resp1_val) chkw("rnd_resp1_msg", 256'(r_resp1_msg), 256'(r_cacheresp_msg));
      if (acc) begin
        m_busy = 1'b1; m_sent = 1'b0; m_owner = win; m_prio = !win;
        m_buf  = win ? r_req1_msg : r_req0_msg;
      end else if (m_busy && !m_sent && r_cachereq_rdy) begin
        m_sent = 1'b1;
      end else if (waiting && r_cacheresp_val && own_rdy) begin
        m_busy = 1'b0;
      end
      next_cycle();
    end
    chk1("rr_slot_overrun", r_slot_overrun, 1'b0);

    // TDM timeline, cycle 0 is the first cycle after reset; slots of 16 cycles
    idle_inputs();
    r_req0_msg = m0_msg; r_req1_msg = m1_msg; r_cacheresp_msg = rsp_msg;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c <= 57; c++) begin
      t_req0_val      = (c >= 5 && c <= 32);
      t_req1_val      = (c >= 1 && c <= 16) || (c >= 46 && c <= 56);
      t_cachereq_rdy  = 1'b1;
      t_cacheresp_val = (c == 18 || c == 54);
      t_resp0_rdy     = 1'b1;
      t_resp1_rdy     = 1'b1;
      @(negedge clk);
      chk1($sformatf("tdm_req0_rdy@%0d", c), t_req0_rdy, c == 32);
      chk1($sformatf("tdm_req1_rdy@%0d", c), t_req1_rdy, c == 16 || c == 56);
      chk1($sformatf("tdm_cachereq_val@%0d", c), t_cachereq_val, c == 17 || c == 33 || c == 57);
      chk1($sformatf("tdm_resp0_val@%0d", c), t_resp0_val, c == 54);
      chk1($sformatf("tdm_resp1_val@%0d", c), t_resp1_val, c == 18);
      chk1($sformatf("tdm_cacheresp_rdy@%0d", c), t_cacheresp_rdy,
           c == 18 || (c >= 34 && c <= 54));
      chk1($sformatf("tdm_slot_overrun@%0d", c), t_slot_overrun, c >= 48);
      if (c == 17 || c == 33 || c == 57)
        chkw($sformatf("tdm_cachereq_msg@%0d", c), 256'(t_cachereq_msg),
             256'((c == 33) ? m0_msg : m1_msg));
      next_cycle();
    end
    idle_inputs();

    // Reset while the round-robin instance waits for a response
    r_req0_val = 1'b1; r_cachereq_rdy = 1'b1; r_resp0_rdy = 1'b1;
    @(negedge clk);
    chk1("rstwait_accept", r_req0_rdy, 1'b1);
    next_cycle();
    r_req0_val = 1'b0;
    @(negedge clk);
    chk1("rstwait_send", r_cachereq_val, 1'b1);
    next_cycle();
    @(negedge clk);
    chk1("rstwait_in_wait", r_cacheresp_rdy, 1'b1);
    chk1("rstwait_overrun_before", t_slot_overrun, 1'b1);
    next_cycle();
    reset = 1'b1;
    r_req0_val = 1'b1; r_req1_val = 1'b1; r_cacheresp_val = 1'b1;
    t_req0_val = 1'b1; t_req1_val = 1'b1; t_cacheresp_val = 1'b1;
    t_resp0_rdy = 1'b1; t_resp1_rdy = 1'b1; r_resp1_rdy = 1'b1;
    @(negedge clk);
    chk_reset_quiet("rstwait");
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk1("after_rst_req0_rdy", r_req0_rdy, 1'b1);
    chk1("after_rst_req1_rdy", r_req1_rdy, 1'b0);
    chk1("after_rst_cachereq_val", r_cachereq_val, 1'b0);
    chk1("after_rst_resp0_val", r_resp0_val, 1'b0);
    chk1("after_rst_resp1_val", r_resp1_val, 1'b0);
    chk1("after_rst_cacheresp_rdy", r_cacheresp_rdy, 1'b0);
    chk1("after_rst_tdm_req0_rdy", t_req0_rdy, 1'b1);
    chk1("after_rst_tdm_req1_rdy", t_req1_rdy, 1'b0);
    chk1("after_rst_slot_overrun", t_slot_overrun, 1'b0);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
